scpad_dram_wr_req_queue: RTL and testbench
==========================================

# scpad_dram_wr_req_queue

Parametrised multi-channel DRAM write-request queue for the scratchpad backend. Collects store requests from NUM_CH scratchpad channels through a round-robin arbiter into one shared FIFO of DEPTH entries. Tags each accepted request with a wrapping DRAM ID and source channel. Drains the FIFO toward the DRAM controller under a stall handshake.

## Interface
Parameters:
- NUM_CH, 4, number of requesting scratchpad channels (≥1)
- DEPTH, 8, FIFO entries (power of 2, ≥2)
- AFULL_THRESH, DEPTH-2, occupancy at or above which almost-full asserts

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- sched_write  in  NUM_CH  per-channel request valid
- wr_req  in  NUM_CH x dram_write_req_t  per-channel dram_addr, num_bytes, wdata
- wr_req_latched  out  NUM_CH  one-hot acceptance pulse for the granted channel
- dram_write_queue_full  out  1  occupancy == DEPTH
- dram_write_queue_afull  out  1  occupancy >= AFULL_THRESH
- occupancy  out  $clog2(DEPTH+1)  current entry count
- be_dram_write_req  out  dram_write_req_t  head entry; valid field set when non-empty
- be_dram_wr_id  out  DRAM_ID_WIDTH  ID of the head entry
- be_dram_wr_src  out  $clog2(NUM_CH) (min 1)  source channel of the head entry
- be_dram_stall  in  1  DRAM controller cannot accept this cycle
- be_dram_wr_req_accepted  out  1  pulse: head dequeued this cycle

## Operation
- Enqueue eligibility: channel i requests when sched_write[i]=1. Grant is issued only when dram_write_queue_full=0. Full is registered, so no same-cycle dequeue credit is taken.
- Arbiter: round-robin. Search starts at channel rr_ptr. On a grant, rr_ptr <= granted+1 mod NUM_CH. With no grant, rr_ptr holds. At most one grant per cycle.
- Granted channel: wr_req_latched[g]=1 for that cycle only. The requester holds sched_write and wr_req until it sees latched.
- num_bytes==0: the request is granted and latched but not written to the FIFO. The ID counter does not advance.
- ID: next_id counter, DRAM_ID_WIDTH bits, assigned at enqueue. Increments by 1 per enqueued entry and wraps 2^W-1 -> 0.
- Dequeue: when the head is valid and be_dram_stall=0, the head pops and be_dram_wr_req_accepted=1 that cycle.
- Simultaneous enqueue and dequeue: occupancy is unchanged and both pointers advance.
- Pointers: $clog2(DEPTH) bits, natural wrap. Occupancy is a separate counter, so there is no full/empty ambiguity.
- Reset, including mid-operation: pointers, occupancy, rr_ptr and next_id go to 0, and all FIFO valids clear. In-flight entries are discarded. All outputs are 0, including be_dram_write_req.valid.

## Timing
- Enqueue latency: an entry granted in cycle N appears at the head in cycle N+1 if the FIFO was empty.
- Head outputs come directly from registered FIFO storage; there is no combinational path from sched_write.
- be_dram_stall → be_dram_wr_req_accepted is combinational (same cycle).
- full and afull reflect the occupancy at the start of the cycle.
- Under continuous requests and no stall, throughput is 1 request/cycle.

## Configuration
- SCPAD_WRQ_BYPASS_EN defined:
  - Condition: FIFO empty, a grant exists, num_bytes≠0 and be_dram_stall=0.
  - Effect: the granted request drives be_dram_write_req / be_dram_wr_id / be_dram_wr_src in the same cycle.
  - accepted=1 and latched=1 in that cycle. Nothing is written to the FIFO; next_id still increments.
  - This introduces a combinational path from sched_write to the DRAM outputs.
- Not defined: all requests go through the FIFO, with a minimum latency of 1 cycle.

## Structure
- scpad_types_pkg holds:
  - DRAM_ADDR_WIDTH, COL_IDX_WIDTH, DRAM_ID_WIDTH, scpad_data_t
  - dram_write_req_t {valid, dram_addr, num_bytes, wdata}
  - dram_wr_entry_t {req, id, src}
- Sub-module scpad_rr_arbiter(NUM_CH): inputs req vector and advance; outputs grant one-hot, grant_idx and grant_valid. Owns rr_ptr.
- The FIFO storage, pointers and ID counter stay in the top module.

## Test plan
- Single request: reset, ch0 writes addr 0x100, 16 bytes, stall=0.
  - latched[0] in cycle 1; head valid in cycle 2 with id 0 and src 0; accepted in cycle 2.
  - With BYPASS_EN: head valid and accepted in cycle 1.
- Round-robin fairness: all 4 channels assert continuously, stall=0.
  - Grant order 0,1,2,3,0…; IDs 0,1,2,3,4….
- Fill and backpressure: stall=1, ch1 issues 10 requests.
  - 8 latched; full=1 at occupancy 8; afull from occupancy 6.
  - After stall=0, the 8 drain in order with IDs 0–7; full drops the cycle after the first pop.
- Zero-byte request: ch2 issues num_bytes=0, then ch2 issues 4 bytes.
  - First: latched pulse only, occupancy stays 0.
  - Second: id 0.
- ID wrap: push and pop 2^DRAM_ID_WIDTH+1 entries → the last ID is 0.
- Reset mid-operation: occupancy 5, assert rst for 1 cycle.
  - Next cycle: occupancy 0, head valid 0, all pulses 0.
  - Next push gets id 0 and the arbiter restarts at ch0.

Source files
------------

// File: rtl/scpad_dram_wr_req_queue_pkg.sv
// Shared types for the scratchpad DRAM write-request queue.
// Holds the request/entry structs, width constants and small index helpers.
package scpad_types_pkg;

    localparam int DRAM_ADDR_WIDTH = 32;
    localparam int COL_IDX_WIDTH   = 5;
    localparam int DRAM_ID_WIDTH   = 4;
    localparam int NUM_BYTES_WIDTH = COL_IDX_WIDTH + 1;
    // Source field is sized for the largest supported channel count.
    localparam int SRC_MAX_W       = 8;

    typedef logic [63:0] scpad_data_t;

    typedef struct packed {
        logic                       valid;
        logic [DRAM_ADDR_WIDTH-1:0] dram_addr;
        logic [NUM_BYTES_WIDTH-1:0] num_bytes;
        scpad_data_t                wdata;
    } dram_write_req_t;

    typedef struct packed {
        dram_write_req_t            req;
        logic [DRAM_ID_WIDTH-1:0]   id;
        logic [SRC_MAX_W-1:0]       src;
    } dram_wr_entry_t;

    // Index width with a floor of one bit, so NUM_CH=1 still has a field.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // (base + off) mod n for base < n and off <= n.
    function automatic int wrap_add(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/scpad_dram_wr_req_queue_if.sv
// Channel-side and DRAM-side signals of the write-request queue.
// slave: queue view (requests in, head/status out); master: client view.
interface scpad_dram_wr_req_queue_if
    import scpad_types_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 8
);
    localparam int SRC_W = idx_width(NUM_CH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [NUM_CH-1:0]        sched_write;
    dram_write_req_t          wr_req [NUM_CH];
    logic [NUM_CH-1:0]        wr_req_latched;
    logic                     dram_write_queue_full;
    logic                     dram_write_queue_afull;
    logic [OCC_W-1:0]         occupancy;
    dram_write_req_t          be_dram_write_req;
    logic [DRAM_ID_WIDTH-1:0] be_dram_wr_id;
    logic [SRC_W-1:0]         be_dram_wr_src;
    logic                     be_dram_stall;
    logic                     be_dram_wr_req_accepted;

    modport slave (
        input  sched_write, wr_req, be_dram_stall,
        output wr_req_latched, dram_write_queue_full,
        output dram_write_queue_afull, occupancy,
        output be_dram_write_req, be_dram_wr_id,
        output be_dram_wr_src, be_dram_wr_req_accepted
    );

    modport master (
        output sched_write, wr_req, be_dram_stall,
        input  wr_req_latched, dram_write_queue_full,
        input  dram_write_queue_afull, occupancy,
        input  be_dram_write_req, be_dram_wr_id,
        input  be_dram_wr_src, be_dram_wr_req_accepted
    );

endinterface

// File: rtl/scpad_dram_wr_req_queue_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from rr_ptr upward.
// Ports: req in, advance in; grant/grant_idx/grant_valid out; owns rr_ptr.
module scpad_rr_arbiter
    import scpad_types_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int IDX_W  = idx_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              grant_valid
);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = IDX_W'(wrap_add(int'(rr_ptr_q), k, NUM_CH));
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance && grant_valid)
            rr_ptr_d = IDX_W'(wrap_add(int'(grant_idx), 1, NUM_CH));
    end

    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end

endmodule

// File: rtl/scpad_dram_wr_req_queue.sv
// Multi-channel DRAM write-request queue: RR arbiter -> shared FIFO -> DRAM.
// Ports: clk, rst (sync, active-high), bus (slave). Option: SCPAD_WRQ_BYPASS_EN.
module scpad_dram_wr_req_queue
    import scpad_types_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = DEPTH - 2
) (
    input logic                      clk,
    input logic                      rst,
    scpad_dram_wr_req_queue_if.slave bus
);

    localparam int SRC_W = idx_width(NUM_CH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    dram_wr_entry_t           mem_q [DEPTH];
    dram_wr_entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]         occ_q, occ_d;
    logic [DRAM_ID_WIDTH-1:0] next_id_q, next_id_d;

    logic [NUM_CH-1:0] arb_req, grant;
    logic [SRC_W-1:0]  grant_idx;
    logic              grant_valid;
    dram_write_req_t   g_req;
    dram_wr_entry_t    new_entry;
    dram_wr_entry_t    out_entry;
    logic              full, head_vld, nonzero;
    logic              bypass, push, pop;

    // Full comes from registered occupancy, so a same-cycle pop
    // never frees a slot for a grant.
    assign full     = (occ_q == OCC_W'(DEPTH));
    assign head_vld = (occ_q != '0);
    assign arb_req  = (rst || full) ? '0 : bus.sched_write;

    scpad_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (arb_req),
        .advance     (!rst),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        g_req                 = bus.wr_req[grant_idx];
        nonzero               = (g_req.num_bytes != '0);
        new_entry             = '0;
        new_entry.req         = g_req;
        new_entry.req.valid   = 1'b1;
        new_entry.id          = next_id_q;
        new_entry.src         = SRC_MAX_W'(grant_idx);
    end

`ifdef SCPAD_WRQ_BYPASS_EN
    // Empty queue and a ready controller: hand the request straight over.
    assign bypass = !head_vld && grant_valid && nonzero
                  && !bus.be_dram_stall;
`else
    assign bypass = 1'b0;
`endif

    // Zero-byte requests are acknowledged but never stored.
    assign push = grant_valid && nonzero && !bypass;
    assign pop  = head_vld && !bus.be_dram_stall && !rst;

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q + OCC_W'(push) - OCC_W'(pop);
        next_id_d = next_id_q;
        if (pop) begin
            mem_d[rd_ptr_q].req.valid = 1'b0;
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (push || bypass)
            next_id_d = next_id_q + DRAM_ID_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            next_id_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            next_id_q <= next_id_d;
        end
    end

    // Head is zeroed while empty so stale slots never leak out.
    always_comb begin
        out_entry = '0;
        if (bypass)
            out_entry = new_entry;
        else if (head_vld)
            out_entry = mem_q[rd_ptr_q];
    end

    assign bus.wr_req_latched          = grant;
    assign bus.dram_write_queue_full   = full;
    assign bus.dram_write_queue_afull  = (occ_q >= OCC_W'(AFULL_THRESH));
    assign bus.occupancy               = occ_q;
    assign bus.be_dram_write_req       = out_entry.req;
    assign bus.be_dram_wr_id           = out_entry.id;
    assign bus.be_dram_wr_src          = SRC_W'(out_entry.src);
    assign bus.be_dram_wr_req_accepted = pop || bypass;

endmodule

// File: tb/tb_scpad_dram_wr_req_queue.sv
// Directed bench for scpad_dram_wr_req_queue (NUM_CH=4, DEPTH=8).
// Expectations follow SCPAD_WRQ_BYPASS_EN when that macro is defined.
module tb_scpad_dram_wr_req_queue;
    import scpad_types_pkg::*;

`ifdef SCPAD_WRQ_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    scpad_dram_wr_req_queue_if #(.NUM_CH(4), .DEPTH(8)) bus ();

    scpad_dram_wr_req_queue #(
        .NUM_CH       (4),
        .DEPTH        (8),
        .AFULL_THRESH (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic dram_write_req_t mk(input logic [31:0] a,
                                           input int nb);
        dram_write_req_t r;
        r.valid     = 1'b1;
        r.dram_addr = a;
        r.num_bytes = NUM_BYTES_WIDTH'(nb);
        r.wdata     = {32'hA5A5_0000, a};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        bus.sched_write = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.sched_write   = '0;
        bus.be_dram_stall = 1'b0;
        for (int i = 0; i < 4; i++) bus.wr_req[i] = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_occ",   64'(bus.occupancy), 0);
        chk("rst_full",  64'(bus.dram_write_queue_full), 0);
        chk("rst_afull", 64'(bus.dram_write_queue_afull), 0);
        chk("rst_vld",   64'(bus.be_dram_write_req.valid), 0);
        chk("rst_acc",   64'(bus.be_dram_wr_req_accepted), 0);
        chk("rst_lat",   64'(bus.wr_req_latched), 0);

        // Single request from ch0
        bus.wr_req[0]   = mk(32'h100, 16);
        bus.sched_write = 4'b0001;
        #1;
        chk("single_lat", 64'(bus.wr_req_latched), 64'h1);
        chk("single_vld_c1", 64'(bus.be_dram_write_req.valid), 64'(BYP));
        chk("single_acc_c1", 64'(bus.be_dram_wr_req_accepted), 64'(BYP));
        step();
        bus.sched_write = '0;
        #1;
        chk("single_vld_c2", 64'(bus.be_dram_write_req.valid), 64'(1 - BYP));
        chk("single_acc_c2", 64'(bus.be_dram_wr_req_accepted), 64'(1 - BYP));
        chk("single_addr", 64'(bus.be_dram_write_req.dram_addr),
            (BYP != 0) ? 64'h0 : 64'h100);
        chk("single_wdata", 64'(bus.be_dram_write_req.wdata),
            (BYP != 0) ? 64'h0 : 64'hA5A5_0000_0000_0100);
        chk("single_id",  64'(bus.be_dram_wr_id), 0);
        chk("single_src", 64'(bus.be_dram_wr_src), 0);
        step();
        #1;
        chk("single_occ_end", 64'(bus.occupancy), 0);

        // Round-robin fairness, all channels active
        reset_dut();
        for (int i = 0; i < 4; i++) bus.wr_req[i] = mk(32'h300 + i, 8);
        bus.sched_write = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_lat", 64'(bus.wr_req_latched), 64'(1 << (k % 4)));
            if (k >= 1) begin
                chk("rr_id",  64'(bus.be_dram_wr_id), 64'(k - 1 + BYP));
                chk("rr_src", 64'(bus.be_dram_wr_src), 64'((k - 1 + BYP) % 4));
                chk("rr_acc", 64'(bus.be_dram_wr_req_accepted), 1);
            end
            step();
        end
        bus.sched_write = '0;
        step();

        // Fill and backpressure from ch1
        reset_dut();
        bus.be_dram_stall = 1'b1;
        bus.sched_write   = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            bus.wr_req[1] = mk(32'h200 + ((k < 8) ? k : 8), 4);
            #1;
            chk("fill_occ",  64'(bus.occupancy), 64'((k < 8) ? k : 8));
            chk("fill_full", 64'(bus.dram_write_queue_full), 64'(k >= 8));
            chk("fill_afull", 64'(bus.dram_write_queue_afull), 64'(k >= 6));
            chk("fill_lat", 64'(bus.wr_req_latched),
                (k < 8) ? 64'h2 : 64'h0);
            chk("fill_acc", 64'(bus.be_dram_wr_req_accepted), 0);
            step();
        end
        bus.sched_write   = '0;
        bus.be_dram_stall = 1'b0;
        for (int j = 0; j < 8; j++) begin
            #1;
            chk("drain_occ",  64'(bus.occupancy), 64'(8 - j));
            chk("drain_full", 64'(bus.dram_write_queue_full), 64'(j == 0));
            chk("drain_vld",  64'(bus.be_dram_write_req.valid), 1);
            chk("drain_id",   64'(bus.be_dram_wr_id), 64'(j));
            chk("drain_addr", 64'(bus.be_dram_write_req.dram_addr),
                64'(32'h200 + j));
            chk("drain_acc",  64'(bus.be_dram_wr_req_accepted), 1);
            step();
        end
        #1;
        chk("drain_occ_end", 64'(bus.occupancy), 0);
        chk("drain_vld_end", 64'(bus.be_dram_write_req.valid), 0);

        // Zero-byte request followed by a real one on ch2
        reset_dut();
        bus.wr_req[2]   = mk(32'h400, 0);
        bus.sched_write = 4'b0100;
        #1;
        chk("zb_lat", 64'(bus.wr_req_latched), 64'h4);
        chk("zb_acc_c1", 64'(bus.be_dram_wr_req_accepted), 0);
        step();
        bus.sched_write = '0;
        #1;
        chk("zb_occ", 64'(bus.occupancy), 0);
        chk("zb_vld", 64'(bus.be_dram_write_req.valid), 0);
        chk("zb_acc", 64'(bus.be_dram_wr_req_accepted), 0);
        bus.wr_req[2]   = mk(32'h404, 4);
        bus.sched_write = 4'b0100;
        #1;
        chk("zb2_lat", 64'(bus.wr_req_latched), 64'h4);
        chk("zb2_vld_c1", 64'(bus.be_dram_write_req.valid), 64'(BYP));
        chk("zb2_src_c1", 64'(bus.be_dram_wr_src), 64'(2 * BYP));
        step();
        bus.sched_write = '0;
        #1;
        chk("zb2_vld_c2", 64'(bus.be_dram_write_req.valid), 64'(1 - BYP));
        chk("zb2_id", 64'(bus.be_dram_wr_id), 0);
        chk("zb2_src_c2", 64'(bus.be_dram_wr_src), 64'(2 * (1 - BYP)));
        step();

        // ID wrap over 17 entries from ch3
        reset_dut();
        bus.wr_req[3]   = mk(32'h500, 8);
        bus.sched_write = 4'b1000;
        for (int k = 0; k < 17; k++) begin
            #1;
            chk("wrap_lat", 64'(bus.wr_req_latched), 64'h8);
            chk("wrap_vld", 64'(bus.be_dram_write_req.valid),
                64'((k >= 1) || (BYP != 0)));
            chk("wrap_id", 64'(bus.be_dram_wr_id),
                (k == 0) ? 64'h0 : 64'((k - 1 + BYP) & 15));
            step();
        end
        bus.sched_write = '0;
        #1;
        chk("wrap_last_vld", 64'(bus.be_dram_write_req.valid), 64'(1 - BYP));
        chk("wrap_last_id", 64'(bus.be_dram_wr_id), 0);
        step();

        // Reset with five entries queued
        reset_dut();
        bus.be_dram_stall = 1'b1;
        bus.wr_req[2]     = mk(32'h600, 4);
        bus.sched_write   = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("mr_lat", 64'(bus.wr_req_latched), 64'h4);
            step();
        end
        bus.sched_write = '0;
        #1;
        chk("mr_occ5", 64'(bus.occupancy), 5);
        chk("mr_afull5", 64'(bus.dram_write_queue_afull), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mr_occ", 64'(bus.occupancy), 0);
        chk("mr_vld", 64'(bus.be_dram_write_req.valid), 0);
        chk("mr_lat0", 64'(bus.wr_req_latched), 0);
        chk("mr_acc0", 64'(bus.be_dram_wr_req_accepted), 0);
        chk("mr_full", 64'(bus.dram_write_queue_full), 0);
        bus.be_dram_stall = 1'b0;
        for (int i = 0; i < 4; i++) bus.wr_req[i] = mk(32'h700 + i, 4);
        bus.sched_write = 4'b1111;
        #1;
        chk("mr_rr_restart", 64'(bus.wr_req_latched), 64'h1);
        step();
        bus.sched_write = '0;
        #1;
        chk("mr_vld_next", 64'(bus.be_dram_write_req.valid), 64'(1 - BYP));
        chk("mr_id_next", 64'(bus.be_dram_wr_id), 0);
        chk("mr_src_next", 64'(bus.be_dram_wr_src), 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
